// File: rtl/ext_add_accum.sv
// ext_add_accum: frame accumulator. Each accepted beat forms a B_WIDTH-bit wrapped sum of
// ext(in_a) + in_b, extends it to ACC_WIDTH and adds it into the frame total. After COUNT
// beats the total is offered on a valid/ready output and held until it is taken.
//
// Optional feature macro: EXT_ADD_ACCUM_SIGNED_EN
//   defined   : in_signed (sampled on the first beat) selects sign-extension and signed overflow
//   undefined : every frame is unsigned (zero-extension, carry overflow), out_signed tied 0
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   input beat handshake
//   in_a [A_WIDTH]       operand a
//   in_b [B_WIDTH]       operand b
//   in_signed            frame signedness, first beat only
//   out_valid, out_ready result handshake
//   out_sum [ACC_WIDTH]  frame total
//   out_ovf              sticky overflow for the frame
//   out_signed           signedness used for the frame
module ext_add_accum #(
  parameter int unsigned A_WIDTH   = 15,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH = 17,
  parameter int unsigned COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf,
  output logic                 out_signed
);

  localparam int unsigned CntW = $clog2(COUNT + 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CntW-1:0]      cnt_q;
  logic                 ovf_q;
  logic                 sgn_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [ACC_WIDTH-1:0] out_sum_q;
  logic                 out_ovf_q;
  logic                 out_signed_q;

  logic                 accept;
  logic                 frame_sgn;
  logic [B_WIDTH-1:0]   a_ext;
  logic [B_WIDTH-1:0]   t16;
  logic [ACC_WIDTH-1:0] term;
  logic [ACC_WIDTH:0]   sum_full;
  logic [ACC_WIDTH-1:0] sum;
  logic                 ovf_beat;
  logic                 ovf_nxt;
  logic [CntW-1:0]      cnt_nxt;

  assign accept = in_valid && in_ready_q;

`ifdef EXT_ADD_ACCUM_SIGNED_EN
  // Signedness is latched on the first beat; later beats reuse the stored flag.
  assign frame_sgn = (state_q == StIdle) ? in_signed : sgn_q;
`else
  logic unused_in_signed;
  assign unused_in_signed = in_signed;
  assign frame_sgn        = 1'b0;
`endif

  always_comb begin
    a_ext = '0;
    term  = '0;
    if (frame_sgn) begin
      a_ext = {{(B_WIDTH - A_WIDTH){in_a[A_WIDTH-1]}}, in_a};
    end else begin
      a_ext = {{(B_WIDTH - A_WIDTH){1'b0}}, in_a};
    end
    // Carry out of the B_WIDTH sum is intentionally dropped.
    t16 = a_ext + in_b;
    if (frame_sgn) begin
      term = {{(ACC_WIDTH - B_WIDTH){t16[B_WIDTH-1]}}, t16};
    end else begin
      term = {{(ACC_WIDTH - B_WIDTH){1'b0}}, t16};
    end
    sum_full = {1'b0, acc_q} + {1'b0, term};
    sum      = sum_full[ACC_WIDTH-1:0];
    if (frame_sgn) begin
      ovf_beat = (acc_q[ACC_WIDTH-1] == term[ACC_WIDTH-1]) &&
                 (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    end else begin
      ovf_beat = sum_full[ACC_WIDTH];
    end
    ovf_nxt = ovf_q | ovf_beat;
    cnt_nxt = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      sgn_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_ovf_q    <= 1'b0;
      out_signed_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            acc_q <= term;
            cnt_q <= CntW'(1);
            ovf_q <= 1'b0;
            sgn_q <= frame_sgn;
            if (COUNT == 1) begin
              state_q      <= StDone;
              in_ready_q   <= 1'b0;
              out_valid_q  <= 1'b1;
              out_sum_q    <= term;
              out_ovf_q    <= 1'b0;
              out_signed_q <= frame_sgn;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StAccum: begin
          if (accept) begin
            acc_q <= sum;
            cnt_q <= cnt_nxt;
            ovf_q <= ovf_nxt;
            if (cnt_nxt == CntW'(COUNT)) begin
              state_q      <= StDone;
              in_ready_q   <= 1'b0;
              out_valid_q  <= 1'b1;
              out_sum_q    <= sum;
              out_ovf_q    <= ovf_nxt;
              out_signed_q <= sgn_q;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q      <= StIdle;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_ovf_q    <= 1'b0;
            out_signed_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_ovf    = out_ovf_q;
  assign out_signed = out_signed_q;

endmodule

// File: tb/tb_ext_add_accum.sv
// Directed, table-driven bench for ext_add_accum with default parameters (COUNT = 4).
module tb_ext_add_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] out_sum;
  logic        out_ovf;
  logic        out_signed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ext_add_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_signed(out_signed)
  );

  typedef struct {
    string       name;
    logic [14:0] a;
    logic [15:0] b;
    logic        sgn_first;
    logic        sgn_rest;
    logic [16:0] exp_sum;
    logic        exp_ovf;
    logic        exp_sgn;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Offer four identical beats; leaves the block in DONE with the result checked.
  task automatic run_frame(input vec_t v);
    wait_ready();
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_a      = v.a;
      in_b      = v.b;
      in_signed = (i == 0) ? v.sgn_first : v.sgn_rest;
      @(posedge clk);
      #1;
      if (i < 3) check({v.name, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    in_valid  = 1'b0;
    in_signed = 1'b0;
    check({v.name, "_valid"}, 32'(out_valid), 32'd1);
    check({v.name, "_sum"}, 32'(out_sum), 32'(v.exp_sum));
    check({v.name, "_ovf"}, 32'(out_ovf), 32'(v.exp_ovf));
    check({v.name, "_signed"}, 32'(out_signed), 32'(v.exp_sgn));
    check({v.name, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic take_result(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_released"}, 32'(out_valid), 32'd0);
    check({name, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[6];
  vec_t v_ones;

  initial begin
    vecs[0] = '{"wrap", 15'h7FFF, 16'hFFFF, 1'b0, 1'b0, 17'h1FFF8, 1'b0, 1'b0};
    vecs[1] = '{"uovf", 15'h0000, 16'hFFFF, 1'b0, 1'b0, 17'h1FFFC, 1'b1, 1'b0};
    vecs[3] = '{"ones", 15'h0001, 16'h0001, 1'b0, 1'b0, 17'h00008, 1'b0, 1'b0};
`ifdef EXT_ADD_ACCUM_SIGNED_EN
    vecs[2] = '{"sgn_first", 15'h0000, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFC, 1'b0, 1'b1};
    vecs[4] = '{"sgn_neg_a", 15'h4000, 16'h0000, 1'b1, 1'b1, 17'h10000, 1'b0, 1'b1};
    vecs[5] = '{"sgn_ovf", 15'h0000, 16'h7FFF, 1'b1, 1'b0, 17'h1FFFC, 1'b1, 1'b1};
`else
    vecs[2] = '{"sgn_first", 15'h0000, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFC, 1'b1, 1'b0};
    vecs[4] = '{"sgn_neg_a", 15'h4000, 16'h0000, 1'b1, 1'b1, 17'h10000, 1'b0, 1'b0};
    vecs[5] = '{"sgn_ovf", 15'h0000, 16'h7FFF, 1'b1, 1'b0, 17'h1FFFC, 1'b0, 1'b0};
`endif
    v_ones = vecs[3];

    // Reset state.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i]);
      take_result(vecs[i].name);
    end

    // Backpressure: result held while out_ready low and in_valid driven.
    run_frame(v_ones);
    in_valid = 1'b1;
    in_a     = 15'h1234;
    in_b     = 16'h4321;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(out_sum), 32'h8);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    take_result("bp");
    check("bp_sum_cleared", 32'(out_sum), 32'd0);

    // Reset in the middle of a frame.
    wait_ready();
    in_valid = 1'b1;
    in_a     = 15'h0100;
    in_b     = 16'h0100;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(out_sum), 32'd0);
    check("mid_rst_ovf", 32'(out_ovf), 32'd0);
    check("mid_rst_signed", 32'(out_signed), 32'd0);
    #1;
    rst_n = 1'b1;
    run_frame(v_ones);
    take_result("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ext_add_accum.md
# ext_add_accum

Frame-based accumulator that sums COUNT beats of mixed-width operand pairs under explicit expression-width rules and hands the total downstream over a valid/ready handshake. Each beat forms a self-determined B_WIDTH-bit sum of a zero- or sign-extended `in_a` and `in_b`. That sum is then extended to ACC_WIDTH and accumulated. It is the sequential producer for the width-extension/cast datapaths in the MIR expression suite and exercises Zext/Sext, IntBinaryArith and sign casts across clocked state.

## Interface
- `A_WIDTH`, 15: width of operand a; must be < B_WIDTH.
- `B_WIDTH`, 16: width of operand b and of the per-beat sum.
- `ACC_WIDTH`, 17: accumulator width; must be > B_WIDTH.
- `COUNT`, 4: beats per frame, ≥ 1.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  beat offered.
- `in_ready`  out  1  block accepts a beat.
- `in_a`  in  A_WIDTH  operand a.
- `in_b`  in  B_WIDTH  operand b.
- `in_signed`  in  1  frame signedness; sampled on the first beat of the frame only.
- `out_valid`  out  1  frame result available.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  ACC_WIDTH  accumulated total.
- `out_ovf`  out  1  sticky overflow for the frame.
- `out_signed`  out  1  signedness used for the frame.

## Operation
- States: IDLE, ACCUM, DONE. Reset → IDLE. Accumulator, count, ovf and signed flag are all 0.
- A beat is accepted when `in_valid && in_ready`. `in_ready` = 1 in IDLE and ACCUM, and 0 in DONE.
- Per-beat term:
  - `t16` = ext(`in_a`, B_WIDTH) + `in_b`, computed at B_WIDTH bits. Carry is discarded (wrap).
  - `term` = ext(`t16`, ACC_WIDTH).
  - ext is zero-extension when the frame is unsigned and sign-extension when it is signed.
- IDLE, beat accepted:
  - acc ← `term`, count ← 1, ovf ← 0, signed flag ← `in_signed`.
  - Next state is DONE if COUNT = 1, otherwise ACCUM.
- ACCUM, beat accepted:
  - acc ← acc + `term`, computed at ACC_WIDTH bits (wrap). count ← count + 1.
  - When count reaches COUNT, go to DONE.
  - `in_signed` is ignored for all beats after the first.
- Overflow, sticky per frame:
  - Unsigned: set on carry out of ACC_WIDTH.
  - Signed: set when acc and `term` have equal MSBs and the result MSB differs.
  - The wrap of `t16` alone never sets ovf.
- DONE:
  - `out_valid` = 1. `out_sum`, `out_ovf` and `out_signed` are held stable until `out_valid && out_ready`, then → IDLE.
  - `in_valid` is ignored in DONE.
- Outputs are register-driven. `out_*` are 0 except in DONE.

## Timing
- Result latency: `out_valid` rises on the clock edge that accepts the COUNT-th beat. It is visible the following cycle.
- Throughput: one beat per cycle within a frame. At least one cycle of DONE separates frames. There is no same-cycle accept/emit bypass, so the first beat of the next frame is accepted no earlier than the cycle after the output transfer.
- Reset assertion at any time:
  - Immediately drives `in_ready`, `out_valid`, `out_sum`, `out_ovf` and `out_signed` to 0 and discards any partial frame.
  - After deassertion the block is in IDLE with `in_ready` = 1 on the first clock.

## Configuration
- `EXT_ADD_ACCUM_SIGNED_EN`:
  - Defined: `in_signed` selects sign-extension and signed overflow as described above.
  - Undefined: `in_signed` is ignored. All frames are unsigned (zero-extension, carry overflow), and `out_signed` is tied 0.

## Test plan
- Width wrap: defaults, unsigned, 4 beats of a=15'h7FFF, b=16'hFFFF. Each `t16` = 16'h7FFE. Expect `out_sum` = 17'h1FFF8, `out_ovf` = 0.
- Unsigned overflow: 4 beats of a=0, b=16'hFFFF, unsigned. Expect `out_sum` = 17'h1FFFC and `out_ovf` = 1, with ovf set on the 3rd beat.
- Signed, with the macro defined: `in_signed` = 1 on beat 1, then 0 on beats 2–4; all beats a=0, b=16'hFFFF. Expect `out_sum` = 17'h1FFFC (−4), `out_ovf` = 0, `out_signed` = 1. With the macro undefined, the same stimulus yields `out_ovf` = 1, `out_signed` = 0.
- Backpressure: hold `out_ready` = 0 for 3 cycles after DONE while driving `in_valid` = 1. Expect the outputs stable and `in_ready` = 0. The result transfers on the first `out_ready` = 1, and `in_ready` = 1 the next cycle.
- Reset mid-frame: accept 2 beats, then pulse `rst_n` low between clock edges. Expect all outputs 0 immediately. A following 4-beat frame of a=1, b=1 yields `out_sum` = 17'h00008.
